// File: rtl/dec_upper_seq.sv
`default_nettype none
// ============================================================================
// Module   : dec_upper_seq
// Brief    : Issue-side sequencer for the upper-immediate (LUI/AUIPC) EXU.
//            Accepts one instruction at a time, holds its decoded fields for
//            EXE_CYCLES execute cycles (stall-aware) and retires it with a
//            one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dec_upper_seq #(
    parameter int EXE_CYCLES = 2
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_instr,
    input  logic [31:0] ifu_pc,
    output logic        ifu_ready,
    input  logic        exu_stall,
    output logic        dec_upper_en,
    output logic        dec_lui,
    output logic        dec_auipc,
    output logic [19:0] dec_imm_type_u,
    output logic [4:0]  dec_rd,
    output logic [31:0] pc,
    output logic [3:0]  cycle_cnt,
    output logic        dec_done,
    output logic        dec_illegal,
    output logic [15:0] ret_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXEC   = 2'd1;
    localparam logic [1:0] c_RETIRE = 2'd2;

    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [3:0] c_CNT_LAST  = 4'(EXE_CYCLES);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [19:0] r_imm;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic        r_lui;
    logic        r_auipc;
    logic        r_illegal;
    logic [15:0] r_ret_cnt;

    logic        w_ready;
    logic        w_accept;
    logic        w_is_lui;
    logic        w_is_auipc;
    logic        w_legal;
    logic        w_take;

    // Ready depends on state only, so fetch never sees a combinational loop.
    assign w_ready    = (r_state != c_EXEC);
    assign w_accept   = ifu_valid && w_ready;
    assign w_is_lui   = (ifu_instr[6:0] == c_OPC_LUI);
    assign w_is_auipc = (ifu_instr[6:0] == c_OPC_AUIPC);
    assign w_legal    = w_is_lui || w_is_auipc;
    assign w_take     = w_accept && w_legal;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_IDLE: begin
                w_cnt_next = 4'd0;
                if (w_take) begin
                    w_state_next = c_EXEC;
                    w_cnt_next   = 4'd1;
                end
            end
            c_EXEC: begin
                if (!exu_stall) begin
                    if (r_cnt < c_CNT_LAST) begin
                        w_cnt_next = r_cnt + 4'd1;
                    end else begin
                        w_state_next = c_RETIRE;
                        w_cnt_next   = 4'd0;
                    end
                end
            end
            c_RETIRE: begin
                // Back-to-back issue: a legal accept here skips IDLE entirely.
                if (w_take) begin
                    w_state_next = c_EXEC;
                    w_cnt_next   = 4'd1;
                end else begin
                    w_state_next = c_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Decoded fields only move on a legal accept; illegal words leave them alone.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_imm   <= 20'd0;
            r_rd    <= 5'd0;
            r_pc    <= 32'd0;
            r_lui   <= 1'b0;
            r_auipc <= 1'b0;
        end else if (w_take) begin
            r_imm   <= ifu_instr[31:12];
            r_rd    <= ifu_instr[11:7];
            r_pc    <= ifu_pc;
            r_lui   <= w_is_lui;
            r_auipc <= w_is_auipc;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_illegal <= 1'b0;
            r_ret_cnt <= 16'd0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (r_state == c_RETIRE) begin
                r_ret_cnt <= r_ret_cnt + 16'd1;
            end
        end
    end

    assign ifu_ready      = w_ready;
    assign dec_upper_en   = (r_state == c_EXEC);
    assign dec_lui        = (r_state == c_EXEC) && r_lui;
    assign dec_auipc      = (r_state == c_EXEC) && r_auipc;
    assign dec_imm_type_u = r_imm;
    assign dec_rd         = r_rd;
    assign pc             = r_pc;
    assign cycle_cnt      = r_cnt;
    assign dec_done       = (r_state == c_RETIRE);
    assign dec_illegal    = r_illegal;
    assign ret_cnt        = r_ret_cnt;

endmodule
`default_nettype wire
